hazard_track_unit: RTL and testbench

ID-stage hazard and forwarding controller placed directly downstream of the decoder. It consumes the decoder's rs1use/rs2use/hazard_optype/Branch together with the ID register indices, and keeps its own registered shadow of the EX and MEM stages (rd, optype, rs2). From that it drives forwarding selects for the ID-stage operand muxes and branch comparator, store-data forwarding at EX, and the PC, IF/ID and ID/EX stall and flush controls. It also keeps stall and flush event counters for performance debug.

---
 rtl/hazard_track_unit.sv | 180 ++++++++++++++++++
 tb/tb_hazard_track_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_track_unit.sv
// hazard_track_unit: ID-stage hazard detection and forwarding control.
// Keeps a registered shadow of the EX and MEM stages (rd, op class, store rs2). From that shadow
// and the current ID instruction it produces three things:
//   - operand forwarding selects for ID,
//   - store-data forwarding at EX,
//   - load-use stall and taken-redirect flush controls.
// Two free-running event counters support performance debug.
module hazard_track_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rd_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [1:0]       hazard_optype_ID,
  input  logic             Branch_ID,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Operation classes carried down the pipeline shadow.
  localparam logic [1:0] OpNone  = 2'b00;
  localparam logic [1:0] OpAlu   = 2'b01;
  localparam logic [1:0] OpLoad  = 2'b10;
  localparam logic [1:0] OpStore = 2'b11;

  // Operand source encoding for the ID-stage muxes.
  localparam logic [1:0] FwdRf     = 2'b00;
  localparam logic [1:0] FwdExAlu  = 2'b01;
  localparam logic [1:0] FwdMemAlu = 2'b10;
  localparam logic [1:0] FwdMemLd  = 2'b11;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // EX and MEM stage shadow.
  logic [4:0]       r_ex_rd;
  logic [1:0]       r_ex_op;
  logic [4:0]       r_ex_rs2;
  logic [4:0]       r_mem_rd;
  logic [1:0]       r_mem_op;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Match terms; x0 never matches and only register-writing ops qualify.
  logic       w_ex_writes;
  logic       w_mem_writes;
  logic       w_rs1_ex_hit;
  logic       w_rs2_ex_hit;
  logic       w_rs1_mem_hit;
  logic       w_rs2_mem_hit;
  logic       w_rs1_en;
  logic       w_rs2_en;
  logic       w_load_stall;
  logic       w_redirect;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_fwd_ls;

  // Newest-first forwarding priority. An EX load match returns regfile: the operand is
  // either covered by the load-use stall or, for store data, forwarded later at EX.
  function automatic logic [1:0] sel_src(input logic       en,
                                         input logic       ex_hit,
                                         input logic [1:0] ex_op,
                                         input logic       mem_hit,
                                         input logic [1:0] mem_op);
    logic [1:0] src;
    src = FwdRf;
    if (en) begin
      if (ex_hit) begin
        src = (ex_op == OpAlu) ? FwdExAlu : FwdRf;
      end else if (mem_hit) begin
        src = (mem_op == OpAlu) ? FwdMemAlu : FwdMemLd;
      end
    end
    return src;
  endfunction

  // Hazard detection and forwarding selects from ID inputs and the stage shadow.
  always_comb begin
    w_ex_writes   = (r_ex_op == OpAlu) || (r_ex_op == OpLoad);
    w_mem_writes  = (r_mem_op == OpAlu) || (r_mem_op == OpLoad);

    w_rs1_ex_hit  = (rs1_ID != 5'd0) && (rs1_ID == r_ex_rd) && w_ex_writes;
    w_rs2_ex_hit  = (rs2_ID != 5'd0) && (rs2_ID == r_ex_rd) && w_ex_writes;
    w_rs1_mem_hit = (rs1_ID != 5'd0) && (rs1_ID == r_mem_rd) && w_mem_writes;
    w_rs2_mem_hit = (rs2_ID != 5'd0) && (rs2_ID == r_mem_rd) && w_mem_writes;

    w_rs1_en      = rs1use_ID;
    // Store data still needs a forwarded value even though it is not an ALU operand.
    w_rs2_en      = rs2use_ID || (hazard_optype_ID == OpStore);

    // Only true operand uses stall; store data from a load is caught by forward_ctrl_ls.
    w_load_stall  = (r_ex_op == OpLoad) &&
                    ((rs1use_ID && w_rs1_ex_hit) || (rs2use_ID && w_rs2_ex_hit));

    w_redirect    = Branch_ID && !w_load_stall;

    w_fwd_a       = sel_src(w_rs1_en, w_rs1_ex_hit, r_ex_op, w_rs1_mem_hit, r_mem_op);
    w_fwd_b       = sel_src(w_rs2_en, w_rs2_ex_hit, r_ex_op, w_rs2_mem_hit, r_mem_op);

    w_fwd_ls      = (r_ex_op == OpStore) && (r_mem_op == OpLoad) &&
                    (r_ex_rs2 != 5'd0) && (r_ex_rs2 == r_mem_rd);
  end

  // Output drive; reset forces a benign free-running pipeline.
  always_comb begin
    forward_ctrl_A  = FwdRf;
    forward_ctrl_B  = FwdRf;
    forward_ctrl_ls = 1'b0;
    PC_EN_IF        = 1'b1;
    reg_FD_EN       = 1'b1;
    reg_FD_flush    = 1'b0;
    reg_DE_flush    = 1'b0;
    if (!rst) begin
      forward_ctrl_A  = w_fwd_a;
      forward_ctrl_B  = w_fwd_b;
      forward_ctrl_ls = w_fwd_ls;
      if (w_load_stall) begin
        // Hold IF and ID, bubble into EX; any redirect waits until the stall clears.
        PC_EN_IF     = 1'b0;
        reg_FD_EN    = 1'b0;
        reg_DE_flush = 1'b1;
      end else if (Branch_ID) begin
        reg_FD_flush = 1'b1;
      end
    end
  end

  // Advance the stage shadow; a stall injects an empty op into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rd  <= 5'd0;
      r_ex_op  <= OpNone;
      r_ex_rs2 <= 5'd0;
      r_mem_rd <= 5'd0;
      r_mem_op <= OpNone;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_op <= r_ex_op;
      if (w_load_stall) begin
        r_ex_rd  <= 5'd0;
        r_ex_op  <= OpNone;
        r_ex_rs2 <= 5'd0;
      end else begin
        r_ex_rd  <= rd_ID;
        r_ex_op  <= hazard_optype_ID;
        r_ex_rs2 <= rs2_ID;
      end
    end
  end

  // Event counters, wrapping naturally at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_load_stall) begin
        r_stall_cnt <= r_stall_cnt + CntOne;
      end
      if (w_redirect) begin
        r_flush_cnt <= r_flush_cnt + CntOne;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_track_unit.sv
// Bench for hazard_track_unit: a reference model pushes expected outputs into a scoreboard queue
// as each ID cycle is driven, and they are popped and compared mid-cycle. Directed hand checks
// cover the named scenarios; a random phase follows.
module tb_hazard_track_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID;
  logic        rs1use_ID, rs2use_ID;
  logic [1:0]  hazard_optype_ID;
  logic        Branch_ID;
  logic [1:0]  forward_ctrl_A, forward_ctrl_B;
  logic        forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_track_unit #(.CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .rs1_ID           (rs1_ID),
    .rs2_ID           (rs2_ID),
    .rd_ID            (rd_ID),
    .rs1use_ID        (rs1use_ID),
    .rs2use_ID        (rs2use_ID),
    .hazard_optype_ID (hazard_optype_ID),
    .Branch_ID        (Branch_ID),
    .forward_ctrl_A   (forward_ctrl_A),
    .forward_ctrl_B   (forward_ctrl_B),
    .forward_ctrl_ls  (forward_ctrl_ls),
    .PC_EN_IF         (PC_EN_IF),
    .reg_FD_EN        (reg_FD_EN),
    .reg_FD_flush     (reg_FD_flush),
    .reg_DE_flush     (reg_DE_flush),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        fls;
    logic        pc;
    logic        fd_en;
    logic        fd_fl;
    logic        de_fl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference pipeline shadow.
  logic [4:0]  m_ex_rd = '0, m_ex_rs2 = '0, m_mem_rd = '0;
  logic [1:0]  m_ex_op = '0, m_mem_op = '0;
  logic [31:0] m_sc = '0, m_fc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] mdl_fwd(input logic [4:0] s, input logic en);
    if (!en || s == 5'd0) return 2'b00;
    if (s == m_ex_rd && m_ex_op == 2'b01) return 2'b01;
    if (s == m_ex_rd && m_ex_op == 2'b10) return 2'b00;
    if (s == m_mem_rd && m_mem_op == 2'b01) return 2'b10;
    if (s == m_mem_rd && m_mem_op == 2'b10) return 2'b11;
    return 2'b00;
  endfunction

  // One ID cycle: drive, predict, advance model, then compare at the falling edge.
  task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic ua, input logic ub,
                      input logic [1:0] op, input logic br);
    exp_t e;
    exp_t g;
    logic ls;
    @(posedge clk);
    #1;
    rst = r; rs1_ID = a; rs2_ID = b; rd_ID = d;
    rs1use_ID = ua; rs2use_ID = ub; hazard_optype_ID = op; Branch_ID = br;
    ls = (m_ex_op == 2'b10) && (m_ex_rd != 5'd0) &&
         ((ua && a == m_ex_rd) || (ub && b == m_ex_rd));
    e.sc = m_sc;
    e.fc = m_fc;
    if (r) begin
      e.fa = 2'b00; e.fb = 2'b00; e.fls = 1'b0;
      e.pc = 1'b1; e.fd_en = 1'b1; e.fd_fl = 1'b0; e.de_fl = 1'b0;
    end else begin
      e.fa    = mdl_fwd(a, ua);
      e.fb    = mdl_fwd(b, ub || (op == 2'b11));
      e.fls   = (m_ex_op == 2'b11) && (m_mem_op == 2'b10) &&
                (m_ex_rs2 != 5'd0) && (m_ex_rs2 == m_mem_rd);
      e.pc    = !ls;
      e.fd_en = !ls;
      e.fd_fl = !ls && br;
      e.de_fl = ls;
    end
    sb_q.push_back(e);
    if (r) begin
      m_ex_rd = '0; m_ex_op = '0; m_ex_rs2 = '0; m_mem_rd = '0; m_mem_op = '0;
      m_sc = '0; m_fc = '0;
    end else begin
      m_mem_rd = m_ex_rd;
      m_mem_op = m_ex_op;
      if (ls) begin
        m_ex_rd = '0; m_ex_op = '0; m_ex_rs2 = '0;
      end else begin
        m_ex_rd = d; m_ex_op = op; m_ex_rs2 = b;
      end
      if (ls) m_sc = m_sc + 1;
      if (br && !ls) m_fc = m_fc + 1;
    end
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      chk("fwd_a", {30'd0, forward_ctrl_A}, {30'd0, g.fa});
      chk("fwd_b", {30'd0, forward_ctrl_B}, {30'd0, g.fb});
      chk("fwd_ls", {31'd0, forward_ctrl_ls}, {31'd0, g.fls});
      chk("pc_en", {31'd0, PC_EN_IF}, {31'd0, g.pc});
      chk("fd_en", {31'd0, reg_FD_EN}, {31'd0, g.fd_en});
      chk("fd_flush", {31'd0, reg_FD_flush}, {31'd0, g.fd_fl});
      chk("de_flush", {31'd0, reg_DE_flush}, {31'd0, g.de_fl});
      chk("stall_cnt", stall_cnt, g.sc);
      chk("flush_cnt", flush_cnt, g.fc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Hazard-looking inputs active throughout reset.
    rst = 1'b1; rs1_ID = 5'd5; rs2_ID = 5'd5; rd_ID = 5'd5;
    rs1use_ID = 1'b1; rs2use_ID = 1'b1; hazard_optype_ID = 2'b10; Branch_ID = 1'b1;

    // Reset then idle.
    step(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 2'b10, 1'b1);
    step(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 2'b10, 1'b1);
    chk("rst_pc_en", {31'd0, PC_EN_IF}, 32'd1);
    chk("rst_fwd_a", {30'd0, forward_ctrl_A}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0);
    chk("idle_x0_pc_en", {31'd0, PC_EN_IF}, 32'd1);

    // ALU back-to-back: EX forward then MEM forward.
    step(1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("alu_ex_fwd", {30'd0, forward_ctrl_A}, 32'd1);
    step(1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("alu_mem_fwd", {30'd0, forward_ctrl_A}, 32'd2);

    // Load-use: one stall cycle, then MEM load forward.
    step(1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 2'b10, 1'b0);
    step(1'b0, 5'd1, 5'd7, 5'd8, 1'b0, 1'b1, 2'b01, 1'b0);
    chk("lu_pc_en", {31'd0, PC_EN_IF}, 32'd0);
    chk("lu_fd_en", {31'd0, reg_FD_EN}, 32'd0);
    chk("lu_de_flush", {31'd0, reg_DE_flush}, 32'd1);
    step(1'b0, 5'd1, 5'd7, 5'd8, 1'b0, 1'b1, 2'b01, 1'b0);
    chk("lu_fwd_b", {30'd0, forward_ctrl_B}, 32'd3);
    chk("lu_pc_after", {31'd0, PC_EN_IF}, 32'd1);
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    // Load then store of the loaded register.
    step(1'b0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 2'b10, 1'b0);
    step(1'b0, 5'd2, 5'd3, 5'd0, 1'b1, 1'b0, 2'b11, 1'b0);
    chk("ls_no_stall", {31'd0, PC_EN_IF}, 32'd1);
    chk("ls_fwd_b", {30'd0, forward_ctrl_B}, 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("ls_fwd_ls", {31'd0, forward_ctrl_ls}, 32'd1);

    // Stall masks branch.
    step(1'b0, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 2'b10, 1'b0);
    step(1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    chk("br_masked", {31'd0, reg_FD_flush}, 32'd0);
    step(1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    chk("br_masked_cnt", flush_cnt, 32'd0);
    chk("br_taken", {31'd0, reg_FD_flush}, 32'd1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("br_flush_cnt", flush_cnt, 32'd1);

    // Priority and x0.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("x0_fwd_a", {30'd0, forward_ctrl_A}, 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 2'b10, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("prio_fwd_a", {30'd0, forward_ctrl_A}, 32'd1);

    // Reset asserted mid-stall clears the shadow.
    step(1'b0, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 2'b10, 1'b0);
    step(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("mid_rst_pc_en", {31'd0, PC_EN_IF}, 32'd1);
    step(1'b0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("post_rst_pc_en", {31'd0, PC_EN_IF}, 32'd1);
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);

    // Random phase over a small register range to provoke matches.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
